// File: rtl/smi_mem_write_split_ctrl.sv
// smi_mem_write_split_ctrl
//
// Splits a byte-addressed write transfer into bursts for a downstream write burst core.
// No burst crosses a MaxBurstBytes-aligned boundary, and at most MaxOutstanding bursts
// may be issued before their completions come back. Once every burst of the transfer
// has completed, one whole-transfer completion is reported, with a status that is the
// AND of all per-burst statuses.
//
// Optional feature macro: SMI_MEM_WRITE_SPLIT_STATS_EN
//   defined   -> statBurstCount counts the bursts issued in the current/last transfer
//   undefined -> no counter is built and statBurstCount is tied to 0
//
// Ports
//   clk, srst                 clock, synchronous active-high reset
//   xferValid/Addr/Len/Opts   transfer request in (xferStop is its back-pressure)
//   burstValid/Addr/Len/Opts  burst request out (burstStop is its back-pressure)
//   burstDoneValid/StatusOk   per-burst completion in (burstDoneStop is its back-pressure)
//   xferDoneValid/StatusOk    whole-transfer completion out (xferDoneStop is its back-pressure)
//   statBurstCount            bursts issued in the current/last transfer
// A handshake transfers only in a cycle where valid=1 and stop=0.

module smi_mem_write_split_ctrl #(
    parameter int unsigned MaxBurstBytes  = 256,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic        clk,
    input  logic        srst,
    // transfer request
    input  logic        xferValid,
    input  logic [63:0] xferAddr,
    input  logic [31:0] xferLen,
    input  logic [7:0]  xferOpts,
    output logic        xferStop,
    // burst request
    output logic        burstValid,
    output logic [63:0] burstAddr,
    output logic [15:0] burstLen,
    output logic [7:0]  burstOpts,
    input  logic        burstStop,
    // burst completion
    input  logic        burstDoneValid,
    input  logic        burstDoneStatusOk,
    output logic        burstDoneStop,
    // transfer completion
    output logic        xferDoneValid,
    output logic        xferDoneStatusOk,
    input  logic        xferDoneStop,
    // statistics
    output logic [15:0] statBurstCount
);

    localparam int unsigned OffW   = $clog2(MaxBurstBytes);
    localparam logic [3:0]  MaxOut = 4'(MaxOutstanding);
    localparam logic [15:0] MaxLen = 16'(MaxBurstBytes);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StReport} state_e;

    state_e      state_q;
    logic [63:0] addr_q;
    logic [31:0] remaining_q;
    logic [7:0]  opts_q;
    logic [3:0]  outstanding_q;
    logic        status_q;

    logic [15:0] room;
    logic        xfer_acc;
    logic        burst_acc;
    logic        done_acc;

    // Bytes left before the next MaxBurstBytes-aligned boundary.
    assign room = MaxLen - {{(16 - OffW){1'b0}}, addr_q[OffW-1:0]};

    always_comb begin
        burstLen = room;
        if (remaining_q < {16'h0, room}) begin
            burstLen = remaining_q[15:0];
        end
    end

    assign burstAddr        = addr_q;
    assign burstOpts        = opts_q;
    assign burstValid       = (state_q == StIssue) && (remaining_q != 32'h0) &&
                              (outstanding_q < MaxOut);
    assign xferStop         = (state_q != StIdle);
    assign burstDoneStop    = (state_q == StIdle) || (state_q == StReport);
    assign xferDoneValid    = (state_q == StReport);
    assign xferDoneStatusOk = (state_q == StReport) && status_q;

    assign xfer_acc  = xferValid && !xferStop;
    assign burst_acc = burstValid && !burstStop;
    assign done_acc  = burstDoneValid && !burstDoneStop;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q       <= StIdle;
            addr_q        <= 64'h0;
            remaining_q   <= 32'h0;
            opts_q        <= 8'h0;
            outstanding_q <= 4'h0;
            status_q      <= 1'b0;
        end else begin
            // Burst/done bookkeeping; both accepts can only occur in Issue/Wait.
            if (burst_acc) begin
                addr_q      <= addr_q + {48'h0, burstLen};
                remaining_q <= remaining_q - {16'h0, burstLen};
            end
            unique case ({burst_acc, done_acc})
                2'b10:   outstanding_q <= outstanding_q + 4'h1;
                2'b01:   outstanding_q <= outstanding_q - 4'h1;
                default: outstanding_q <= outstanding_q;
            endcase
            if (done_acc) begin
                status_q <= status_q & burstDoneStatusOk;
            end

            unique case (state_q)
                StIdle: begin
                    if (xfer_acc) begin
                        addr_q        <= xferAddr;
                        remaining_q   <= xferLen;
                        opts_q        <= xferOpts;
                        outstanding_q <= 4'h0;
                        status_q      <= 1'b1;
                        state_q       <= (xferLen == 32'h0) ? StReport : StIssue;
                    end
                end
                StIssue: begin
                    // A final burst always leaves at least one burst outstanding.
                    if (burst_acc && (remaining_q == {16'h0, burstLen})) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (done_acc && (outstanding_q == 4'h1)) begin
                        state_q <= StReport;
                    end
                end
                StReport: begin
                    if (!xferDoneStop) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef SMI_MEM_WRITE_SPLIT_STATS_EN
    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= 16'h0;
        end else if (xfer_acc) begin
            count_q <= 16'h0;
        end else if (burst_acc && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'h1;
        end
    end

    assign statBurstCount = count_q;
`else
    assign statBurstCount = 16'h0;
`endif

endmodule

// File: tb/tb_smi_mem_write_split_ctrl.sv
// Directed bench for smi_mem_write_split_ctrl with default parameters (256-byte bursts,
// 4 outstanding). Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_smi_mem_write_split_ctrl;

`ifdef SMI_MEM_WRITE_SPLIT_STATS_EN
    localparam bit StatsOn = 1'b1;
`else
    localparam bit StatsOn = 1'b0;
`endif

    logic        clk;
    logic        srst;
    logic        xferValid;
    logic [63:0] xferAddr;
    logic [31:0] xferLen;
    logic [7:0]  xferOpts;
    logic        xferStop;
    logic        burstValid;
    logic [63:0] burstAddr;
    logic [15:0] burstLen;
    logic [7:0]  burstOpts;
    logic        burstStop;
    logic        burstDoneValid;
    logic        burstDoneStatusOk;
    logic        burstDoneStop;
    logic        xferDoneValid;
    logic        xferDoneStatusOk;
    logic        xferDoneStop;
    logic [15:0] statBurstCount;

    int n_vec = 0;
    int n_err = 0;
    int nb;

    smi_mem_write_split_ctrl #(
        .MaxBurstBytes (256),
        .MaxOutstanding(4)
    ) dut (
        .clk              (clk),
        .srst             (srst),
        .xferValid        (xferValid),
        .xferAddr         (xferAddr),
        .xferLen          (xferLen),
        .xferOpts         (xferOpts),
        .xferStop         (xferStop),
        .burstValid       (burstValid),
        .burstAddr        (burstAddr),
        .burstLen         (burstLen),
        .burstOpts        (burstOpts),
        .burstStop        (burstStop),
        .burstDoneValid   (burstDoneValid),
        .burstDoneStatusOk(burstDoneStatusOk),
        .burstDoneStop    (burstDoneStop),
        .xferDoneValid    (xferDoneValid),
        .xferDoneStatusOk (xferDoneStatusOk),
        .xferDoneStop     (xferDoneStop),
        .statBurstCount   (statBurstCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [63:0] a, input logic [31:0] l, input logic [7:0] o);
        xferValid = 1'b1;
        xferAddr  = a;
        xferLen   = l;
        xferOpts  = o;
        step();
        xferValid = 1'b0;
    endtask

    task automatic finish_report(input logic exp_ok);
        chk("done_valid", 64'(xferDoneValid), 64'd1);
        chk("done_ok", 64'(xferDoneStatusOk), 64'(exp_ok));
        xferDoneStop = 1'b0;
        step();
        xferDoneStop = 1'b1;
        chk("idle_xfer_stop", 64'(xferStop), 64'd0);
    endtask

    function automatic logic [63:0] expcnt(input int n);
        return StatsOn ? 64'(n) : 64'd0;
    endfunction

    initial begin
        srst = 1'b1;
        xferValid = 1'b0;
        xferAddr = 64'h0;
        xferLen = 32'h0;
        xferOpts = 8'h0;
        burstStop = 1'b0;
        burstDoneValid = 1'b0;
        burstDoneStatusOk = 1'b1;
        xferDoneStop = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_burst_valid", 64'(burstValid), 64'd0);
        chk("rst_done_valid", 64'(xferDoneValid), 64'd0);
        chk("rst_done_ok", 64'(xferDoneStatusOk), 64'd0);
        chk("rst_done_stop", 64'(burstDoneStop), 64'd1);
        chk("rst_count", 64'(statBurstCount), 64'd0);
        srst = 1'b0;
        step();
        chk("rst_xfer_stop", 64'(xferStop), 64'd0);

        // Aligned 1 KiB: four 256-byte bursts, with one back-pressured cycle up front
        burstStop = 1'b1;
        start(64'h1000, 32'd1024, 8'h5A);
        chk("t1_valid0", 64'(burstValid), 64'd1);
        chk("t1_addr0", burstAddr, 64'h1000);
        chk("t1_len0", 64'(burstLen), 64'd256);
        chk("t1_opts", 64'(burstOpts), 64'h5A);
        chk("t1_xfer_stop", 64'(xferStop), 64'd1);
        chk("t1_bdone_stop", 64'(burstDoneStop), 64'd0);
        step();
        chk("t1_stable_addr", burstAddr, 64'h1000);
        chk("t1_stable_len", 64'(burstLen), 64'd256);
        burstStop = 1'b0;
        step();
        chk("t1_addr1", burstAddr, 64'h1100);
        step();
        chk("t1_addr2", burstAddr, 64'h1200);
        step();
        chk("t1_addr3", burstAddr, 64'h1300);
        chk("t1_valid3", 64'(burstValid), 64'd1);
        step();
        chk("t1_valid_end", 64'(burstValid), 64'd0);
        chk("t1_count", 64'(statBurstCount), expcnt(4));
        burstDoneValid = 1'b1;
        step();
        step();
        step();
        chk("t1_not_yet_done", 64'(xferDoneValid), 64'd0);
        step();
        burstDoneValid = 1'b0;
        finish_report(1'b1);
        chk("t1_count_hold", 64'(statBurstCount), expcnt(4));

        // Unaligned: split at the 0x1100 boundary
        start(64'h10F0, 32'h40, 8'h00);
        chk("t2_count_clr", 64'(statBurstCount), 64'd0);
        chk("t2_addr0", burstAddr, 64'h10F0);
        chk("t2_len0", 64'(burstLen), 64'h10);
        step();
        chk("t2_addr1", burstAddr, 64'h1100);
        chk("t2_len1", 64'(burstLen), 64'h30);
        step();
        chk("t2_valid_end", 64'(burstValid), 64'd0);
        chk("t2_count", 64'(statBurstCount), expcnt(2));
        burstDoneValid = 1'b1;
        step();
        step();
        burstDoneValid = 1'b0;
        finish_report(1'b1);

        // 4 KiB with no completions: window closes after 4 bursts
        start(64'h0, 32'd4096, 8'h00);
        step();
        step();
        step();
        step();
        chk("t3_window_closed", 64'(burstValid), 64'd0);
        step();
        chk("t3_still_closed", 64'(burstValid), 64'd0);
        burstDoneValid = 1'b1;
        step();
        burstDoneValid = 1'b0;
        chk("t3_fifth_valid", 64'(burstValid), 64'd1);
        chk("t3_fifth_addr", burstAddr, 64'h400);
        // Completions every cycle from here: bursts and dones overlap
        burstDoneValid = 1'b1;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (xferDoneValid) break;
            if (burstValid) nb++;
            step();
        end
        burstDoneValid = 1'b0;
        chk("t3_remaining_bursts", 64'(nb), 64'd12);
        chk("t3_count", 64'(statBurstCount), expcnt(16));
        finish_report(1'b1);

        // Three bursts, second completes with error
        start(64'h2000, 32'h300, 8'h00);
        step();
        step();
        step();
        chk("t4_valid_end", 64'(burstValid), 64'd0);
        burstDoneValid = 1'b1;
        burstDoneStatusOk = 1'b1;
        step();
        burstDoneStatusOk = 1'b0;
        step();
        chk("t4_not_yet_done", 64'(xferDoneValid), 64'd0);
        burstDoneStatusOk = 1'b1;
        step();
        burstDoneValid = 1'b0;
        finish_report(1'b0);

        // Zero length: straight to Report, held by xferDoneStop
        start(64'h40, 32'h0, 8'h00);
        chk("t5_no_burst", 64'(burstValid), 64'd0);
        chk("t5_done_valid", 64'(xferDoneValid), 64'd1);
        chk("t5_done_ok", 64'(xferDoneStatusOk), 64'd1);
        chk("t5_count", 64'(statBurstCount), 64'd0);
        step();
        step();
        chk("t5_held", 64'(xferDoneValid), 64'd1);
        chk("t5_held_no_burst", 64'(burstValid), 64'd0);
        finish_report(1'b1);

        // Reset mid-transfer, then a clean transfer
        start(64'h1000, 32'd1024, 8'h00);
        step();
        step();
        chk("t6_addr2", burstAddr, 64'h1200);
        srst = 1'b1;
        step();
        chk("t6_rst_valid", 64'(burstValid), 64'd0);
        chk("t6_rst_done", 64'(xferDoneValid), 64'd0);
        chk("t6_rst_bdone_stop", 64'(burstDoneStop), 64'd1);
        chk("t6_rst_count", 64'(statBurstCount), 64'd0);
        srst = 1'b0;
        step();
        chk("t6_xfer_stop", 64'(xferStop), 64'd0);
        chk("t6_idle_done", 64'(xferDoneValid), 64'd0);
        start(64'h3000, 32'h200, 8'h33);
        chk("t6_new_addr0", burstAddr, 64'h3000);
        chk("t6_new_len0", 64'(burstLen), 64'h100);
        step();
        chk("t6_new_addr1", burstAddr, 64'h3100);
        step();
        chk("t6_new_valid_end", 64'(burstValid), 64'd0);
        burstDoneValid = 1'b1;
        step();
        step();
        burstDoneValid = 1'b0;
        finish_report(1'b1);
        chk("t6_count", 64'(statBurstCount), expcnt(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/smi_mem_write_split_ctrl.md
SMI_MEM_WRITE_SPLIT_CTRL -- requirements
Module: smi_mem_write_split_ctrl

Interface
REQ-001 SHALL have parameter MaxBurstBytes, default 256: maximum burst size in bytes; power of two, 8..4096.
REQ-002 SHALL have parameter MaxOutstanding, default 4: maximum issued bursts awaiting completion; 1..15.
REQ-003 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-004 SHALL have port srst, input, 1: reset; synchronous, active-high.
REQ-005 SHALL have ports xferValid in 1, xferAddr in 64, xferLen in 32 (bytes), xferOpts in 8, xferStop out 1: transfer request handshake.
REQ-006 SHALL have ports burstValid out 1, burstAddr out 64, burstLen out 16 (bytes), burstOpts out 8, burstStop in 1: burst parameter handshake toward the write burst core.
REQ-007 SHALL have ports burstDoneValid in 1, burstDoneStatusOk in 1, burstDoneStop out 1: per-burst completion from the write burst core.
REQ-008 SHALL have ports xferDoneValid out 1, xferDoneStatusOk out 1, xferDoneStop in 1: whole-transfer completion.
REQ-009 SHALL have port statBurstCount, output, 16: bursts issued in current/last transfer.

Function
REQ-010 SHALL transfer on any handshake only in cycles where valid=1 and stop=0.
REQ-011 SHALL implement states Idle, Issue, Wait, Report.
REQ-012 Idle: xferStop=0; on accept, latch addr, remaining=xferLen, opts, outstanding=0, status=1; next state Issue, or Report if xferLen=0.
REQ-013 Issue: burstValid=1 when remaining!=0 and outstanding<MaxOutstanding; otherwise 0.
REQ-014 burstLen SHALL equal min(remaining, MaxBurstBytes - (addr mod MaxBurstBytes)); no burst crosses a MaxBurstBytes-aligned (hence 4 KiB) boundary.
REQ-015 On burst accept: addr+=burstLen (64-bit wrap), remaining-=burstLen, outstanding+=1, statBurstCount+=1 (saturating at 16'hFFFF).
REQ-016 burstAddr/burstLen/burstOpts SHALL be stable while burstValid=1 and burstStop=1.
REQ-017 burstDoneStop SHALL be 0 in Issue and Wait, 1 in Idle and Report.
REQ-018 On done accept: outstanding-=1; status&=burstDoneStatusOk.
REQ-019 Simultaneous burst accept and done accept SHALL leave outstanding unchanged and apply both status and address updates.
REQ-020 Issue->Wait when remaining reaches 0; Wait->Report when outstanding reaches 0 (including via the final cycle's done accept).
REQ-021 Report: xferDoneValid=1, xferDoneStatusOk=status; on ~xferDoneStop go Idle; xferStop=1 in all states but Idle.
REQ-022 First burst SHALL be offered the cycle after transfer accept; back-to-back bursts at one per cycle when burstStop=0 and window open.
REQ-023 Zero-length transfer SHALL issue no bursts and report xferDoneStatusOk=1.
REQ-024 statBurstCount SHALL clear on transfer accept and hold through Report and Idle.

Reset
REQ-025 srst SHALL force Idle, outstanding=0, remaining=0, status=0, statBurstCount=0.
REQ-026 During and after reset cycle: burstValid=0, xferDoneValid=0, xferDoneStatusOk=0, xferStop=0 after release, burstDoneStop=1.
REQ-027 srst mid-transfer SHALL abandon it with no completion reported; downstream reset is the system's responsibility.

Configuration
REQ-028 Macro SMI_MEM_WRITE_SPLIT_STATS_EN: defined -> statBurstCount counter per REQ-015/024; undefined -> counter not built, statBurstCount tied to 0; all other behaviour identical.

Verification
REQ-029 xferAddr=0x1000, xferLen=1024, stops low -> 4 bursts, len 256 at 0x1000/0x1100/0x1200/0x1300, consecutive cycles; xferDoneStatusOk=1.
REQ-030 xferAddr=0x10F0, xferLen=0x40 -> bursts (0x10F0,0x10) then (0x1100,0x30); statBurstCount=2 (macro on).
REQ-031 xferLen=4096, burstDoneValid held 0 -> exactly 4 bursts issued then burstValid=0; releasing one done -> fifth burst next cycle.
REQ-032 3-burst transfer, second done has StatusOk=0 -> xferDoneValid with xferDoneStatusOk=0 only after third done.
REQ-033 xferLen=0 -> no burstValid; xferDoneValid=1, StatusOk=1 one cycle after accept; xferDoneStop=1 holds Report.
REQ-034 srst asserted after 2 of 4 bursts -> next cycle Idle, burstValid=0, xferStop=0 after release; new transfer runs normally.
